// File: rtl/sprite_pkg.sv
// ============================================================================
// sprite_pkg : shared types, geometry and colour constants for sprite_plotter
// Revision   : 1.0
// ============================================================================
`default_nettype none

package sprite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PLOT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int PRESS_W_DEF = 40;
    localparam int PRESS_H_DEF = 60;
    localparam int GARB_W_DEF  = 20;
    localparam int GARB_H_DEF  = 20;

    localparam logic [6:0] PRESS_Y0   = 7'd30;
    localparam logic [6:0] GARB_Y0    = 7'd95;
    localparam logic [7:0] SLOT_PITCH = 8'd40;
    localparam logic [7:0] GARB_X_OFF = 8'd10;

    localparam logic [2:0] PRESS_POS_MAX = 3'd5;
    localparam logic [2:0] GARB_POS_MAX  = 3'd3;

    localparam logic [2:0] COL_ERASE = 3'b000;
    localparam logic [2:0] COL_PRESS = 3'b111;
    localparam logic [2:0] COL_GARB  = 3'b010;

    // Positions 4 and 5 fold back onto slots 2 and 1 (press travels out and back).
    function automatic logic [1:0] press_slot(input logic [2:0] pos);
        logic [1:0] slot;
        case (pos)
            3'd0:    slot = 2'd0;
            3'd1:    slot = 2'd1;
            3'd2:    slot = 2'd2;
            3'd3:    slot = 2'd3;
            3'd4:    slot = 2'd2;
            3'd5:    slot = 2'd1;
            default: slot = 2'd0;
        endcase
        return slot;
    endfunction

endpackage

`default_nettype wire

// File: rtl/raster_counter.sv
// ============================================================================
// raster_counter : row-major 2D pixel counter, size chosen at runtime by sel_i
// Revision       : 1.0
// ============================================================================
`default_nettype none

module raster_counter #(
    parameter int W1 = 40,
    parameter int H1 = 60,
    parameter int W0 = 20,
    parameter int H0 = 20
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic       sel_i,
    output logic [5:0] px_o,
    output logic [5:0] py_o,
    output logic       last_o
);

    localparam logic [5:0] W1_MAX = 6'(W1 - 1);
    localparam logic [5:0] H1_MAX = 6'(H1 - 1);
    localparam logic [5:0] W0_MAX = 6'(W0 - 1);
    localparam logic [5:0] H0_MAX = 6'(H0 - 1);

    logic [5:0] px_q;
    logic [5:0] py_q;
    logic [5:0] w_max;
    logic [5:0] h_max;
    logic       px_wrap;
    logic       py_wrap;

    assign w_max   = sel_i ? W1_MAX : W0_MAX;
    assign h_max   = sel_i ? H1_MAX : H0_MAX;
    assign px_wrap = (px_q == w_max);
    assign py_wrap = (py_q == h_max);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            px_q <= 6'd0;
            py_q <= 6'd0;
        end else if (clear_i) begin
            px_q <= 6'd0;
            py_q <= 6'd0;
        end else if (enable_i) begin
            if (px_wrap) begin
                px_q <= 6'd0;
                py_q <= py_wrap ? 6'd0 : py_q + 6'd1;
            end else begin
                px_q <= px_q + 6'd1;
            end
        end
    end

    assign px_o   = px_q;
    assign py_o   = py_q;
    assign last_o = px_wrap && py_wrap;

endmodule

`default_nettype wire

// File: rtl/sprite_plotter.sv
// ============================================================================
// sprite_plotter : handshaked draw/erase sweep for press and garbage sprites
// Revision       : 1.0
// ============================================================================
`default_nettype none

module sprite_plotter
    import sprite_pkg::*;
#(
    parameter int PRESS_W = PRESS_W_DEF,
    parameter int PRESS_H = PRESS_H_DEF,
    parameter int GARB_W  = GARB_W_DEF,
    parameter int GARB_H  = GARB_H_DEF
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_item,
    input  logic       req_erase,
    input  logic [2:0] req_pos,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [5:0] PRESS_W_MAX = 6'(PRESS_W - 1);
    localparam logic [5:0] GARB_W_MAX  = 6'(GARB_W - 1);

    state_e     state_q, state_d;
    logic       ready_en_q;
    logic       item_q, erase_q;
    logic [2:0] pos_q;
    logic [7:0] ox_q;
    logic [6:0] oy_q;
    logic [7:0] x_q;
    logic [6:0] y_q;
    logic [2:0] colour_q;

    logic       latch_en, load_setup, step_en, cnt_clear, cnt_enable;
    logic       pos_ok;
    logic [7:0] ox_setup;
    logic [6:0] oy_setup;
    logic [2:0] col_setup;
    logic [5:0] px, py, px_nxt, py_nxt, w_max;
    logic       last, px_wrap;

    raster_counter #(
        .W1 (PRESS_W),
        .H1 (PRESS_H),
        .W0 (GARB_W),
        .H0 (GARB_H)
    ) u_raster (
        .clk_i    (CLOCK_50),
        .rst_ni   (reset_n),
        .clear_i  (cnt_clear),
        .enable_i (cnt_enable),
        .sel_i    (item_q),
        .px_o     (px),
        .py_o     (py),
        .last_o   (last)
    );

    assign pos_ok    = item_q ? (pos_q <= PRESS_POS_MAX) : (pos_q <= GARB_POS_MAX);
    assign ox_setup  = item_q ? ({6'd0, press_slot(pos_q)} * SLOT_PITCH)
                              : ({6'd0, pos_q[1:0]} * SLOT_PITCH + GARB_X_OFF);
    assign oy_setup  = item_q ? PRESS_Y0 : GARB_Y0;
    assign col_setup = erase_q ? COL_ERASE : (item_q ? COL_PRESS : COL_GARB);

    // x/y are registered one pixel ahead of the counter so the first pixel is
    // already on the outputs in the first PLOT cycle.
    assign w_max   = item_q ? PRESS_W_MAX : GARB_W_MAX;
    assign px_wrap = (px == w_max);
    assign px_nxt  = px_wrap ? 6'd0 : px + 6'd1;
    assign py_nxt  = px_wrap ? py + 6'd1 : py;

    always_comb begin
        state_d    = state_q;
        latch_en   = 1'b0;
        load_setup = 1'b0;
        step_en    = 1'b0;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_en_q) begin
                    latch_en = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_clear = 1'b1;
                if (pos_ok) begin
                    load_setup = 1'b1;
                    state_d    = ST_PLOT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_PLOT: begin
                cnt_enable = 1'b1;
                if (last) begin
                    state_d = ST_DONE;
                end else begin
                    step_en = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            item_q   <= 1'b0;
            erase_q  <= 1'b0;
            pos_q    <= 3'd0;
            ox_q     <= 8'd0;
            oy_q     <= 7'd0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'd0;
        end else begin
            if (latch_en) begin
                item_q  <= req_item;
                erase_q <= req_erase;
                pos_q   <= req_pos;
            end
            if (load_setup) begin
                ox_q     <= ox_setup;
                oy_q     <= oy_setup;
                x_q      <= ox_setup;
                y_q      <= oy_setup;
                colour_q <= col_setup;
            end else if (step_en) begin
                x_q <= ox_q + {2'd0, px_nxt};
                y_q <= oy_q + {1'b0, py_nxt};
            end
        end
    end

    assign req_ready = ready_en_q && (state_q == ST_IDLE);
    assign plot      = (state_q == ST_PLOT);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign x         = x_q;
    assign y         = y_q;
    assign colour    = colour_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_plotter.sv
// ============================================================================
// tb_sprite_plotter : directed vector table plus corner sequences for sprite_plotter
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_sprite_plotter;

    logic       clk;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_item;
    logic       req_erase;
    logic [2:0] req_pos;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int n_total = 0;
    int n_pass  = 0;

    sprite_plotter dut (
        .CLOCK_50  (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_item  (req_item),
        .req_erase (req_erase),
        .req_pos   (req_pos),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       item;
        logic       erase;
        logic [2:0] pos;
        int         nplots;
        int         fx, fy, lx, ly;
        int         col;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic wait_ready(input string tag);
        int w;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " ready_before_req"}, int'(req_ready), 1);
    endtask

    // Issues one single-cycle request and checks the whole sweep.
    task automatic run_vec(input vec_t v, input string tag);
        int np, fx, fy, lx, ly, dc, bad_col, oob, busy_bad;
        np = 0; fx = -1; fy = -1; lx = -1; ly = -1; dc = -1;
        bad_col = 0; oob = 0; busy_bad = 0;
        @(negedge clk);
        wait_ready(tag);
        req_item  = v.item;
        req_erase = v.erase;
        req_pos   = v.pos;
        req_valid = 1'b1;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0;
                req_item  = ~v.item;
                req_erase = ~v.erase;
                req_pos   = 3'd0;
            end
            if (!busy) busy_bad++;
            if (plot) begin
                if (np == 0) begin
                    fx = int'(x);
                    fy = int'(y);
                end
                lx = int'(x);
                ly = int'(y);
                np++;
                if (int'(colour) != v.col) bad_col++;
                if (x > 8'd159 || y > 7'd119) oob++;
            end
            if (done) begin
                dc = c;
                break;
            end
        end
        chk({tag, " done_cycle"}, dc, v.nplots + 2);
        chk({tag, " plot_count"}, np, v.nplots);
        chk({tag, " colour_errors"}, bad_col, 0);
        chk({tag, " out_of_range"}, oob, 0);
        chk({tag, " busy_gaps"}, busy_bad, 0);
        if (v.nplots > 0) begin
            chk({tag, " first_x"}, fx, v.fx);
            chk({tag, " first_y"}, fy, v.fy);
            chk({tag, " last_x"}, lx, v.lx);
            chk({tag, " last_y"}, ly, v.ly);
        end
        chk({tag, " ready_in_done"}, int'(req_ready), 0);
        @(negedge clk);
        chk({tag, " ready_after_done"}, int'(req_ready), 1);
        chk({tag, " busy_after_done"}, int'(busy), 0);
        if (v.nplots > 0) chk({tag, " x_hold"}, int'(x), v.lx);
    endtask

    vec_t vecs[12];

    initial begin
        int np, fx, fy, lx, ly, dc, bad_col, plot_in_rst, done_seen;

        vecs[0]  = '{1'b0, 1'b0, 3'd2, 400,   90, 95, 109, 114, 2};
        vecs[1]  = '{1'b1, 1'b1, 3'd4, 2400,  80, 30, 119,  89, 0};
        vecs[2]  = '{1'b0, 1'b0, 3'd7, 0,      0,  0,   0,   0, 0};
        vecs[3]  = '{1'b1, 1'b0, 3'd0, 2400,   0, 30,  39,  89, 7};
        vecs[4]  = '{1'b1, 1'b0, 3'd1, 2400,  40, 30,  79,  89, 7};
        vecs[5]  = '{1'b1, 1'b0, 3'd2, 2400,  80, 30, 119,  89, 7};
        vecs[6]  = '{1'b1, 1'b0, 3'd3, 2400, 120, 30, 159,  89, 7};
        vecs[7]  = '{1'b1, 1'b0, 3'd5, 2400,  40, 30,  79,  89, 7};
        vecs[8]  = '{1'b0, 1'b0, 3'd0, 400,   10, 95,  29, 114, 2};
        vecs[9]  = '{1'b0, 1'b1, 3'd1, 400,   50, 95,  69, 114, 0};
        vecs[10] = '{1'b0, 1'b0, 3'd3, 400,  130, 95, 149, 114, 2};
        vecs[11] = '{1'b1, 1'b0, 3'd6, 0,      0,  0,   0,   0, 0};

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_item  = 1'b0;
        req_erase = 1'b0;
        req_pos   = 3'd0;

        repeat (3) @(negedge clk);
        chk("rst ready", int'(req_ready), 0);
        chk("rst plot", int'(plot), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst xy_colour", int'({x, y, colour}), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst ready", int'(req_ready), 1);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Valid held high across a whole sweep; second request's fields change mid-sweep.
        @(negedge clk);
        wait_ready("queue");
        req_item = 1'b0; req_erase = 1'b0; req_pos = 3'd1; req_valid = 1'b1;
        np = 0; fx = -1; fy = -1; lx = -1; ly = -1; dc = -1; bad_col = 0;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            if (c == 100) begin
                req_item = 1'b1; req_erase = 1'b1; req_pos = 3'd3;
            end
            if (plot) begin
                if (np == 0) begin
                    fx = int'(x);
                    fy = int'(y);
                end
                lx = int'(x);
                ly = int'(y);
                np++;
                if (colour != 3'b010) bad_col++;
            end
            if (done) begin
                dc = c;
                break;
            end
        end
        chk("queue first_count", np, 400);
        chk("queue first_done", dc, 402);
        chk("queue first_x0", fx, 50);
        chk("queue first_y0", fy, 95);
        chk("queue first_xl", lx, 69);
        chk("queue first_yl", ly, 114);
        chk("queue first_colour_err", bad_col, 0);
        chk("queue ready_in_done", int'(req_ready), 0);
        @(negedge clk);
        chk("queue ready_c403", int'(req_ready), 1);
        @(negedge clk);
        chk("queue setup_plot_c404", int'(plot), 0);
        chk("queue setup_busy_c404", int'(busy), 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("queue second_plot_c405", int'(plot), 1);
        chk("queue second_x0", int'(x), 120);
        chk("queue second_y0", int'(y), 30);
        chk("queue second_colour", int'(colour), 0);
        dc = -1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) begin
                dc = c;
                break;
            end
        end
        chk("queue second_done_c", dc, 2399);

        // Reset asserted at the 200th pixel of a press draw.
        @(negedge clk);
        @(negedge clk);
        wait_ready("rstmid");
        req_item = 1'b1; req_erase = 1'b0; req_pos = 3'd0; req_valid = 1'b1;
        np = 0;
        for (int c = 1; c <= 400 && np < 200; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (plot) np++;
        end
        chk("rstmid reached_200", np, 200);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid plot", int'(plot), 0);
        chk("rstmid busy", int'(busy), 0);
        chk("rstmid ready", int'(req_ready), 0);
        chk("rstmid xy_colour", int'({x, y, colour}), 0);
        plot_in_rst = 0; done_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (plot) plot_in_rst++;
            if (done) done_seen++;
        end
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (plot) plot_in_rst++;
            if (done) done_seen++;
        end
        chk("rstmid no_plot", plot_in_rst, 0);
        chk("rstmid no_done", done_seen, 0);
        chk("rstmid ready_after", int'(req_ready), 1);
        run_vec(vecs[8], "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sprite_plotter.md
# sprite_plotter

Handshaked pixel-sweep engine between the game FSMs and `vga_adapter`. It accepts one draw or erase request for a press or garbage sprite at a slot position and emits a raster of (x, y, colour, plot) writes. When the sweep finishes it pulses `done`, so the game FSMs can sequence draw and erase steps on completion instead of on fixed delay counts. It is the stage directly downstream of the game FSMs and directly upstream of the VGA adapter.

## Interface
Parameters:
- `PRESS_W`, 40: press sprite width in pixels.
- `PRESS_H`, 60: press sprite height in pixels.
- `GARB_W`, 20: garbage sprite width in pixels.
- `GARB_H`, 20: garbage sprite height in pixels.

Ports:
- `CLOCK_50`  in  1  system clock.
- `reset_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  engine can accept a request.
- `req_item`  in  1  sprite select: 1 = press, 0 = garbage.
- `req_erase`  in  1  1 = paint black, 0 = paint sprite colour.
- `req_pos`  in  3  position: press 0–5, garbage 0–3.
- `x`  out  8  pixel column, 0–159.
- `y`  out  7  pixel row, 0–119.
- `colour`  out  3  RGB, 1 bit per channel.
- `plot`  out  1  write strobe to `vga_adapter`.
- `busy`  out  1  high from the accept cycle through the `done` cycle.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, SETUP, PLOT, DONE.
  - IDLE: `req_ready`=1. On `req_valid`, latch item, erase and pos, then go to SETUP.
  - SETUP: compute the origin and colour, clear the raster counters, then go to PLOT.
  - PLOT: `plot`=1 every cycle. Pixels are emitted in row-major order, x innermost. After the last pixel, go to DONE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- Request fields are sampled only at accept. Later changes are ignored.
- Press slot map, pos → slot: 0→0, 1→1, 2→2, 3→3, 4→2, 5→1.
- Press origin: (40·slot, 30). Covers y 30–89.
- Garbage origin: (40·pos+10, 95). Covers y 95–114.
- Colour:
  - Erase: 3'b000.
  - Press: 3'b111.
  - Garbage: 3'b010.
- Invalid position (press pos > 5, or garbage pos > 3, including 3'b111 meaning "no garbage"):
  - The request is accepted.
  - SETUP goes directly to DONE.
  - Zero pixels are plotted.
  - `done` still pulses, so no caller can hang.
- Arithmetic:
  - x = ox + px, 8-bit; y = oy + py, 7-bit.
  - The constants guarantee no overflow.
  - px is 6-bit and wraps to 0 at W−1; py then increments.
  - The last pixel is px=W−1 and py=H−1.
- `x`, `y` and `colour` are registered and change only in PLOT. Outside PLOT they hold their last value.

## Timing
- Accept at cycle 0. SETUP at cycle 1. Pixel plots at cycles 2 through W·H+1. `done` at W·H+2. `req_ready` high again at W·H+3.
  - Press: 2400 plot cycles, `done` at 2402.
  - Garbage: 400 plot cycles, `done` at 402.
- Invalid request: accept at 0, SETUP at 1, `done` at 2.
- Back-to-back requests: minimum spacing is W·H+3 cycles. `req_valid` held high while `req_ready`=0 is not accepted until IDLE.
- Reset values: `req_ready`=0 during reset, and 1 on the first cycle after release. `plot`, `busy`, `done`, `x`, `y` and `colour` are all 0. State is IDLE.
- `reset_n` low mid-sweep: all outputs clear immediately (asynchronously). No further pixels are plotted and no `done` is issued. The in-flight request is lost.
- `req_valid` in the same cycle that `done` is high is not accepted. `req_ready` is 0 in DONE.

## Structure
- Package `sprite_pkg` holds:
  - State encoding (2-bit enum).
  - Sprite sizes.
  - Y origins 30 and 95.
  - Slot pitch 40 and garbage x offset 10.
  - Colour constants.
  - The press pos→slot function.
- Sub-module `raster_counter`:
  - Parameterised 2D counter with runtime width/height select.
  - Inputs: clear, enable.
  - Outputs: px, py, last.
  - Instantiated once.

## Test plan
- Garbage draw, pos 2, erase 0: exactly 400 `plot` cycles.
  - First pixel (90,95) colour 010; last pixel (109,114).
  - `done` exactly 402 cycles after accept.
- Press erase, pos 4: slot 2, 2400 plots, all colour 000.
  - First pixel (80,30); last pixel (119,89).
- Invalid garbage pos 3'b111: zero plots, `done` at cycle 2, `req_ready` high at cycle 3.
- `req_valid` held continuously with two queued requests:
  - The second is accepted only at cycle W·H+3.
  - The second request's fields, changed mid-sweep, do not alter the first sweep's pixels.
- `reset_n` dropped at plot 200 of a press draw:
  - `plot` and `busy` go 0 the same cycle.
  - No `done` pulse.
  - After release, `req_ready`=1 and a new garbage request completes normally.
- Every plotted (x, y) lies within 0–159 × 0–119, checked across all 6 press and 4 garbage positions.
